// File: rtl/lru_alloc_pkg.sv
// Shared types and sizing helpers for the LRU slot allocator.
package lru_alloc_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StEvict,
    StGrant
  } alloc_state_e;

  localparam int unsigned DEFAULT_SLOTS = 4;
  localparam int unsigned DEFAULT_SLOTW = $clog2(DEFAULT_SLOTS);

  function automatic int unsigned slot_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/VX_priority_encoder.sv
// Lowest-index set-bit encoder; valid_out flags any bit set.
module VX_priority_encoder #(
  parameter int unsigned N  = 4,
  parameter int unsigned LN = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  data_in,
  output logic [LN-1:0] index,
  output logic          valid_out
);

  always_comb begin
    index = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (data_in[i]) index = LN'(i);
    end
  end

  assign valid_out = |data_in;

endmodule

// File: rtl/lru_slot_alloc.sv
// Slot allocator with LRU ordering; forces a victim writeback handshake before
// granting when the pool is full.
module lru_slot_alloc
  import lru_alloc_pkg::*;
#(
  parameter int unsigned NUM_SLOTS = DEFAULT_SLOTS,
  parameter int unsigned SLOTW     = slot_w(NUM_SLOTS),
  parameter int unsigned CNTW      = $clog2(NUM_SLOTS + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alloc_valid,
  output logic             alloc_ready,
  output logic [SLOTW-1:0] alloc_slot,
  input  logic             touch_valid,
  input  logic [SLOTW-1:0] touch_slot,
  input  logic             release_valid,
  input  logic [SLOTW-1:0] release_slot,
  output logic             evict_valid,
  output logic [SLOTW-1:0] evict_slot,
  input  logic             evict_ready,
  output logic [CNTW-1:0]  used_count,
  output logic             full
);

  localparam logic [CNTW-1:0] FullCnt = CNTW'(NUM_SLOTS);

  alloc_state_e         r_state, w_state_d;
  logic [NUM_SLOTS-1:0] r_used, w_used_d;
  logic [SLOTW-1:0]     r_ptr   [NUM_SLOTS];
  logic [SLOTW-1:0]     w_ptr_d [NUM_SLOTS];
  logic [CNTW-1:0]      r_count, w_count_d;
  logic                 r_full;
  logic [SLOTW-1:0]     r_victim, w_victim_d;

  logic [SLOTW-1:0]     w_free_idx;
  logic                 w_free_any;
  logic                 w_fire, w_remove, w_append;
  logic [SLOTW-1:0]     w_op_slot, w_pos;

  VX_priority_encoder #(
    .N  (NUM_SLOTS),
    .LN (SLOTW)
  ) u_free_enc (
    .data_in   (~r_used),
    .index     (w_free_idx),
    .valid_out (w_free_any)
  );

  always_comb begin
    alloc_ready = 1'b0;
    alloc_slot  = (r_state == StGrant) ? r_victim : w_free_idx;
    if (!release_valid && !touch_valid) begin
      if (r_state == StIdle)  alloc_ready = w_free_any;
      if (r_state == StGrant) alloc_ready = 1'b1;
    end
  end

  assign w_fire      = alloc_valid & alloc_ready;
  assign evict_valid = (r_state == StEvict);
  assign evict_slot  = r_victim;
  assign used_count  = r_count;
  assign full        = r_full;

  // Every list update is "remove if present, then optionally append at MRU".
  always_comb begin
    w_op_slot = alloc_slot;
    w_remove  = 1'b0;
    w_append  = 1'b0;
    if (release_valid) begin
      w_op_slot = release_slot;
      w_remove  = r_used[release_slot];
    end else if (touch_valid) begin
      w_op_slot = touch_slot;
      w_remove  = r_used[touch_slot];
      w_append  = r_used[touch_slot];
    end else if (w_fire) begin
      w_remove  = r_used[alloc_slot];
      w_append  = 1'b1;
    end
  end

  always_comb begin
    w_pos = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (CNTW'(i) < r_count && r_ptr[i] == w_op_slot) w_pos = SLOTW'(i);
    end
  end

  always_comb begin
    w_ptr_d   = r_ptr;
    w_count_d = r_count;
    if (w_remove) begin
      for (int i = 0; i < NUM_SLOTS - 1; i++) begin
        if (SLOTW'(i) >= w_pos) w_ptr_d[i] = r_ptr[i+1];
      end
      w_count_d = w_count_d - CNTW'(1);
    end
    if (w_append) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (CNTW'(i) == w_count_d) w_ptr_d[i] = w_op_slot;
      end
      w_count_d = w_count_d + CNTW'(1);
    end
  end

  always_comb begin
    w_used_d = r_used;
    if (release_valid)  w_used_d[release_slot] = 1'b0;
    else if (w_fire)    w_used_d[alloc_slot]   = 1'b1;
  end

  always_comb begin
    w_state_d  = r_state;
    w_victim_d = r_victim;
    unique case (r_state)
      StIdle: begin
        if (alloc_valid && !release_valid && !touch_valid && r_full) begin
          w_victim_d = r_ptr[0];
          w_state_d  = StEvict;
        end
      end
      StEvict: if (evict_ready) w_state_d = StGrant;
      StGrant: if (w_fire) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= StIdle;
      r_used   <= '0;
      r_ptr    <= '{default: '0};
      r_count  <= '0;
      r_full   <= 1'b0;
      r_victim <= '0;
    end else begin
      r_state  <= w_state_d;
      r_used   <= w_used_d;
      r_ptr    <= w_ptr_d;
      r_count  <= w_count_d;
      r_full   <= (w_count_d == FullCnt);
      r_victim <= w_victim_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(w_remove && r_count == '0)) else $error("lru_slot_alloc: count underflow");
      assert (!(w_append && !w_remove && r_count == FullCnt))
        else $error("lru_slot_alloc: count overflow");
    end
  end

endmodule

// File: tb/tb_lru_slot_alloc.sv
// Directed plus random stimulus against a queue-based LRU model of the allocator.
module tb_lru_slot_alloc;

  logic       clk = 1'b0;
  logic       reset, alloc_valid, touch_valid, release_valid, evict_ready;
  logic [1:0] touch_slot, release_slot;
  logic       alloc_ready, evict_valid, full;
  logic [1:0] alloc_slot, evict_slot;
  logic [2:0] used_count;

  int n_vec  = 0;
  int n_fail = 0;

  // Model: queue front = LRU, back = MRU; mode 0 idle, 1 evicting, 2 granting.
  int       q[$];
  bit [3:0] mused;
  int       mode;
  int       victim;

  lru_slot_alloc #(.NUM_SLOTS(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .alloc_valid   (alloc_valid),
    .alloc_ready   (alloc_ready),
    .alloc_slot    (alloc_slot),
    .touch_valid   (touch_valid),
    .touch_slot    (touch_slot),
    .release_valid (release_valid),
    .release_slot  (release_slot),
    .evict_valid   (evict_valid),
    .evict_slot    (evict_slot),
    .evict_ready   (evict_ready),
    .used_count    (used_count),
    .full          (full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    n_vec++;
    assert (obs === 32'(exp))
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int lowest_free();
    for (int i = 0; i < 4; i++) if (!mused[i]) return i;
    return 0;
  endfunction

  function automatic bit exp_ready();
    return !release_valid && !touch_valid && ((mode == 0 && q.size() < 4) || mode == 2);
  endfunction

  function automatic int exp_slot();
    return (mode == 2) ? victim : lowest_free();
  endfunction

  function automatic void qremove(input int s);
    for (int i = 0; i < q.size(); i++) begin
      if (q[i] == s) begin
        q.delete(i);
        break;
      end
    end
  endfunction

  task automatic check_outputs();
    bit rdy;
    rdy = exp_ready();
    chk("alloc_ready", alloc_ready, rdy);
    if (rdy) chk("alloc_slot", alloc_slot, exp_slot());
    chk("evict_valid", evict_valid, mode == 1);
    if (mode == 1) chk("evict_slot", evict_slot, victim);
    chk("used_count", used_count, q.size());
    chk("full", full, q.size() == 4);
  endtask

  task automatic model_step();
    bit rdy;
    int slot;
    if (reset) begin
      q.delete();
      mused  = '0;
      mode   = 0;
      victim = 0;
      return;
    end
    rdy  = exp_ready();
    slot = exp_slot();
    case (mode)
      0: if (alloc_valid && !release_valid && !touch_valid && q.size() == 4) begin
        victim = q[0];
        mode   = 1;
      end
      1: if (evict_ready) mode = 2;
      default: if (alloc_valid && rdy) mode = 0;
    endcase
    if (release_valid) begin
      if (mused[release_slot]) begin
        qremove(int'(release_slot));
        mused[release_slot] = 1'b0;
      end
    end else if (touch_valid) begin
      if (mused[touch_slot]) begin
        qremove(int'(touch_slot));
        q.push_back(int'(touch_slot));
      end
    end else if (alloc_valid && rdy) begin
      qremove(slot);
      q.push_back(slot);
      mused[slot] = 1'b1;
    end
  endtask

  task automatic drive(input bit av, input bit tv, input int ts, input bit rv, input int rs,
                       input bit er);
    alloc_valid   = av;
    touch_valid   = tv;
    touch_slot    = 2'(ts);
    release_valid = rv;
    release_slot  = 2'(rs);
    evict_ready   = er;
    #2;
    if (!reset) check_outputs();
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    mused = '0;
    mode  = 0;
    victim = 0;
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    tick();
    tick();
    reset = 1'b0;

    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 0, 0, 0);
      chk("fill_slot", alloc_slot, i);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0);
    chk("fill_full", full, 1);
    chk("fill_count", used_count, 4);
    tick();

    // Touch 0, so slot 1 becomes the victim; hold off writeback three cycles.
    drive(0, 1, 0, 0, 0, 0); tick();
    drive(1, 0, 0, 0, 0, 0);
    chk("evict_req_not_ready", alloc_ready, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 0, 0);
      chk("evict_hold_valid", evict_valid, 1);
      chk("evict_hold_slot", evict_slot, 1);
      tick();
    end
    drive(1, 0, 0, 0, 0, 1); tick();
    drive(1, 0, 0, 0, 0, 0);
    chk("grant_slot", alloc_slot, 1);
    tick();

    drive(0, 0, 0, 1, 2, 0); tick();
    drive(1, 0, 0, 0, 0, 0);
    chk("refill_slot", alloc_slot, 2);
    tick();

    drive(1, 1, 3, 1, 1, 0);
    chk("combo_not_ready", alloc_ready, 0);
    tick();
    drive(1, 0, 0, 0, 0, 0);
    chk("combo_grant", alloc_slot, 1);
    tick();

    // Order is now 3,0,2,1: victim 3 is released mid-eviction.
    drive(1, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 1, 3, 0);
    chk("rel_victim_slot", evict_slot, 3);
    tick();
    drive(0, 0, 0, 0, 0, 1); tick();
    drive(1, 0, 0, 0, 0, 0);
    chk("regrant_slot", alloc_slot, 3);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    chk("regrant_count", used_count, 4);
    tick();

    drive(1, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0); tick();
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0); tick();
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    chk("rst_evict_valid", evict_valid, 0);
    chk("rst_count", used_count, 0);
    chk("rst_slot", alloc_slot, 0);
    tick();

    for (int n = 0; n < 1500; n++) begin
      reset = ($urandom_range(0, 299) == 0);
      drive($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 20, $urandom_range(0, 3),
            $urandom_range(0, 99) < 15, $urandom_range(0, 3), $urandom_range(0, 99) < 50);
      tick();
    end
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
